aes_pipeline_stage_ghash: RTL

Final stage of the AES-GCM datapath, downstream of the AES round stages. Consumes fully encrypted H, J0 and counter blocks together with plaintext, AAD and length data, one 128-bit block per accepted transfer. Produces ciphertext blocks immediately and the authentication tag at instance end. GHASH uses a digit-serial GF(2^128) multiplier, so the block applies valid/ready backpressure upstream.

---
 rtl/aes_pipeline_stage_ghash_if.sv | 48 ++++
 rtl/aes_pipeline_stage_ghash.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/aes_pipeline_stage_ghash_if.sv
// ---------------------------------------------------------------------------
// aes_pipeline_stage_ghash_if
// Block-level bus of the AES-GCM final stage.
//
// Handshake: a block transfers on a rising clk edge where i_valid && o_ready
// are both 1. The master holds every i_* field stable while i_valid=1 and
// o_ready=0; the slave samples the fields only on the transfer edge.
// o_ct_valid / o_tag_valid are single-cycle strobes with no back-pressure.
//
// Signals (bit 0 of every 128-bit field is the x^0 coefficient):
//   i_valid, o_ready         block handshake
//   i_phase                  1 AAD, 2 plaintext, 3 length block, else bubble
//   i_new_instance           first block of a GCM instance
//   i_plain_text, i_aad      data operands
//   i_h, i_encrypted_j0      E(K,0^128) and E(K,J0), used at instance start
//   i_encrypted_cb           E(K,CB) for the current plaintext block
//   i_instance_size          {len(A), len(C)} in bits
//   o_ct_valid, o_cipher_text  ciphertext strobe and block
//   o_tag_valid, o_tag         tag strobe and value
// ---------------------------------------------------------------------------
interface aes_pipeline_stage_ghash_if;
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_phase;
  logic         i_new_instance;
  logic [0:127] i_plain_text;
  logic [0:127] i_aad;
  logic [0:127] i_h;
  logic [0:127] i_encrypted_j0;
  logic [0:127] i_encrypted_cb;
  logic [0:127] i_instance_size;
  logic         o_ct_valid;
  logic [0:127] o_cipher_text;
  logic         o_tag_valid;
  logic [0:127] o_tag;

  modport master (
    output i_valid, i_phase, i_new_instance, i_plain_text, i_aad, i_h,
           i_encrypted_j0, i_encrypted_cb, i_instance_size,
    input  o_ready, o_ct_valid, o_cipher_text, o_tag_valid, o_tag
  );

  modport slave (
    input  i_valid, i_phase, i_new_instance, i_plain_text, i_aad, i_h,
           i_encrypted_j0, i_encrypted_cb, i_instance_size,
    output o_ready, o_ct_valid, o_cipher_text, o_tag_valid, o_tag
  );
endinterface

// File: rtl/aes_pipeline_stage_ghash.sv
// ---------------------------------------------------------------------------
// aes_pipeline_stage_ghash
// Final AES-GCM stage: produces ciphertext C = P ^ E(K,CB) and accumulates
// GHASH Y = (Y ^ X) * H over AAD, ciphertext and length blocks with a
// digit-serial GF(2^128) multiplier, then emits tag = Y ^ E(K,J0).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          aes_pipeline_stage_ghash_if.slave (handshake, data, results)
//   dbg_state_o  current FSM state (0 IDLE, 1 MULT, 2 TAG)
//
// Build option:
//   AES_GCM_GHASH_DIGIT16_EN  16 multiply steps per cycle (8 MULT cycles);
//                             otherwise 8 steps per cycle (16 MULT cycles).
//                             Results are identical in both builds.
// ---------------------------------------------------------------------------
module aes_pipeline_stage_ghash (
  input  logic                          clk,
  input  logic                          rst_n,
  aes_pipeline_stage_ghash_if.slave     bus,
  output logic [1:0]                    dbg_state_o
);

`ifdef AES_GCM_GHASH_DIGIT16_EN
  localparam int unsigned DIGIT = 16;
`else
  localparam int unsigned DIGIT = 8;
`endif
  localparam int unsigned MULT_CYCLES = 128 / DIGIT;
  localparam int unsigned CW          = $clog2(MULT_CYCLES);
  // Reduction constant x^7+x^2+x+1 in GCM bit order.
  localparam logic [0:127] R_POLY = {8'he1, 120'd0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_TAG  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [0:127]  y_q, y_d, z_q, z_d, v_q, v_d, a_q, a_d;
  logic [0:127]  h_q, h_d, ej0_q, ej0_d, ct_q, ct_d, tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          final_q, final_d, ct_vld_q, ct_vld_d, tag_vld_q, tag_vld_d;

  logic          accept, phase_ok;
  logic [0:127]  c_blk, x_op, y_base, h_sel, z_step, v_step;

  // Operand selection and one multiplier digit.
  always_comb begin
    accept   = bus.i_valid && (state_q == S_IDLE);
    phase_ok = (bus.i_phase == 3'd1) || (bus.i_phase == 3'd2) ||
               (bus.i_phase == 3'd3);
    c_blk    = bus.i_plain_text ^ bus.i_encrypted_cb;
    case (bus.i_phase)
      3'd1:    x_op = bus.i_aad;
      3'd2:    x_op = c_blk;
      default: x_op = bus.i_instance_size;
    endcase
    y_base = bus.i_new_instance ? '0 : y_q;
    h_sel  = bus.i_new_instance ? bus.i_h : h_q;

    // A is shifted toward index 0 each cycle, so the digit always sits in
    // A[0:DIGIT-1] and the bits are consumed in order 0..127.
    z_step = z_q;
    v_step = v_q;
    for (int j = 0; j < DIGIT; j++) begin
      if (a_q[j]) z_step = z_step ^ v_step;
      v_step = v_step[127] ? ((v_step >> 1) ^ R_POLY) : (v_step >> 1);
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    z_d       = z_q;
    v_d       = v_q;
    a_d       = a_q;
    h_d       = h_q;
    ej0_d     = ej0_q;
    ct_d      = ct_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    final_d   = final_q;
    ct_vld_d  = 1'b0;
    tag_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Bubbles are accepted (o_ready=1) but leave everything untouched.
        if (accept && phase_ok) begin
          h_d     = h_sel;
          ej0_d   = bus.i_new_instance ? bus.i_encrypted_j0 : ej0_q;
          z_d     = '0;
          v_d     = h_sel;
          a_d     = y_base ^ x_op;
          cnt_d   = '0;
          final_d = (bus.i_phase == 3'd3);
          state_d = S_MULT;
          if (bus.i_phase == 3'd2) begin
            ct_d     = c_blk;
            ct_vld_d = 1'b1;
          end
        end
      end
      S_MULT: begin
        z_d   = z_step;
        v_d   = v_step;
        a_d   = a_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MULT_CYCLES - 1)) begin
          y_d = z_step;
          if (final_q) begin
            // Registered so the strobe lines up with the TAG state cycle.
            tag_d     = z_step ^ ej0_q;
            tag_vld_d = 1'b1;
            state_d   = S_TAG;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TAG:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      z_q       <= '0;
      v_q       <= '0;
      a_q       <= '0;
      h_q       <= '0;
      ej0_q     <= '0;
      ct_q      <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      final_q   <= 1'b0;
      ct_vld_q  <= 1'b0;
      tag_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      z_q       <= z_d;
      v_q       <= v_d;
      a_q       <= a_d;
      h_q       <= h_d;
      ej0_q     <= ej0_d;
      ct_q      <= ct_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      final_q   <= final_d;
      ct_vld_q  <= ct_vld_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  assign bus.o_ready       = (state_q == S_IDLE);
  assign bus.o_ct_valid    = ct_vld_q;
  assign bus.o_cipher_text = ct_q;
  assign bus.o_tag_valid   = tag_vld_q;
  assign bus.o_tag         = tag_q;
  assign dbg_state_o       = state_q;

endmodule
